adc_spi_reader: RTL
===================

ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 SHALL have parameter NUM_ADC, default 2: number of ADCs sharing CS/SCLK, each with its own DOUT line (1..8).
REQ-002 SHALL have parameter DATA_BITS, default 16: conversion width per ADC (8..24).
REQ-003 SHALL have parameter LEAD_BITS, default 4: SCLK cycles before the MSB appears (leading zeros).
REQ-004 SHALL have parameter TOTAL_CLKS, default 24: SCLK cycles per frame; LEAD_BITS+DATA_BITS <= TOTAL_CLKS.
REQ-005 SHALL have parameter SCLK_HALF, default 1: dataclk cycles per SCLK half-period (>=1).
REQ-006 SHALL have parameter CS_SETUP, default 1: dataclk cycles from CS falling to first SCLK falling edge (>=1).
REQ-007 SHALL have port dataclk, input, 1: sole clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port start, input, 1: frame request, sampled only in IDLE.
REQ-010 SHALL have port abort, input, 1: terminate the frame in progress.
REQ-011 SHALL have port signed_mode, input, 1: convert offset-binary to two's complement; captured with start.
REQ-012 SHALL have port ADC_DOUT, input, NUM_ADC: serial data, bit i from ADC i.
REQ-013 SHALL have port ADC_CS, output, 1: shared chip select, active low.
REQ-014 SHALL have port ADC_SCLK, output, 1: shared serial clock, idles high.
REQ-015 SHALL have port ADC_data, output, NUM_ADC*DATA_BITS: ADC i result in bits [i*DATA_BITS +: DATA_BITS].
REQ-016 SHALL have port busy, output, 1: frame in progress.
REQ-017 SHALL have port done, output, 1: one-cycle pulse on frame completion.

Function
REQ-018 SHALL implement states IDLE, SETUP, SHIFT_LO, SHIFT_HI; all outputs registered.
REQ-019 IDLE: CS=1, SCLK=1, busy=0; start=1 and abort=0 -> SETUP, CS<=0, busy<=1, signed_mode latched, shift registers cleared.
REQ-020 SETUP: CS=0, SCLK=1 for CS_SETUP cycles -> SHIFT_LO with SCLK<=0.
REQ-021 SHIFT_LO lasts SCLK_HALF cycles -> SHIFT_HI with SCLK<=1; all ADC_DOUT bits are sampled on that same edge.
REQ-022 SHIFT_HI lasts SCLK_HALF cycles -> SHIFT_LO, SCLK<=0, if fewer than TOTAL_CLKS rising edges have been issued.
REQ-023 SCLK rising edge k (0-based) SHALL be captured iff LEAD_BITS <= k < LEAD_BITS+DATA_BITS; data arrives MSB first.
REQ-024 At the end of the last SHIFT_HI SHALL go to IDLE with CS<=1, SCLK<=1, busy<=0, done<=1, and ADC_data loaded from the shift registers, all on one edge.
REQ-025 If signed_mode was latched as 1, SHALL invert the MSB of each word when loading ADC_data.
REQ-026 ADC_data SHALL change only on a done edge (double-buffered) and hold its value otherwise.
REQ-027 done SHALL rise exactly CS_SETUP + 2*SCLK_HALF*TOTAL_CLKS edges after the start-sampling edge; with defaults, 49 edges.
REQ-028 start while busy SHALL be ignored; start in the done cycle (IDLE) SHALL be accepted.
REQ-029 abort in any non-IDLE state SHALL, next edge: go to IDLE, CS<=1, SCLK<=1, busy<=0, done stays 0, ADC_data unchanged.
REQ-030 start and abort together in IDLE: abort wins, no frame.
REQ-031 Bit and half-period counters SHALL be sized from parameters and never wrap within a frame.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, ADC_CS=1, ADC_SCLK=1, busy=0, done=0, ADC_data=0, counters and shift registers 0, latched signed_mode=0.
REQ-033 A reset asserted mid-frame SHALL discard the frame; first frame after release requires new start.

Verification (defaults unless stated)
REQ-034 ADC0 serial 0x8001, ADC1 0x7FFE after 4 zeros, signed_mode=0, start -> CS low 49 cycles, 24 SCLK pulses, done at edge 49, ADC_data={0x7FFE,0x8001}.
REQ-035 Same data, signed_mode=1 -> ADC_data={0xFFFE,0x0001}.
REQ-036 abort after 10th SCLK rise -> next edge CS=1, SCLK=1, busy=0, no done, ADC_data keeps prior value.
REQ-037 start pulsed at SCLK 5 of an active frame -> ignored, single done; start held through done -> back-to-back frame, CS high one cycle between frames.
REQ-038 reset asserted asynchronously mid-SHIFT_LO -> CS and SCLK high before next dataclk edge, ADC_data=0.
REQ-039 SCLK_HALF=3, CS_SETUP=2, DATA_BITS=12, LEAD_BITS=2, TOTAL_CLKS=16 -> SCLK period 6 cycles, done after 98 edges, 12-bit word correct.

Source files
------------

// File: rtl/adc_spi_reader.sv
// adc_spi_reader
//   Reads NUM_ADC serial ADCs that share one chip select and one serial clock.
//   Each ADC returns a frame of TOTAL_CLKS bits on its own DOUT line.
//   LEAD_BITS leading bits are skipped, then DATA_BITS bits arrive MSB first.
//   Every ADC_DOUT bit is sampled on the dataclk edge that raises ADC_SCLK.
//   Completed words are copied into ADC_data on the done edge.
//   With signed_mode latched high, each word's MSB is flipped on that copy,
//   converting offset binary to two's complement.
//
// Ports
//   dataclk      : sole clock, rising edge
//   reset        : asynchronous, active-high reset
//   start        : frame request, honoured only in IDLE
//   abort        : ends the frame in progress on the next edge
//   signed_mode  : offset-binary to two's-complement conversion, latched with start
//   ADC_DOUT     : serial data, bit i from ADC i
//   ADC_CS       : shared chip select, active low
//   ADC_SCLK     : shared serial clock, idles high
//   ADC_data     : ADC i result in bits [i*DATA_BITS +: DATA_BITS]
//   busy         : frame in progress
//   done         : one-cycle pulse when a frame completes
module adc_spi_reader #(
    parameter int NUM_ADC    = 2,
    parameter int DATA_BITS  = 16,
    parameter int LEAD_BITS  = 4,
    parameter int TOTAL_CLKS = 24,
    parameter int SCLK_HALF  = 1,
    parameter int CS_SETUP   = 1
) (
    input  logic                           dataclk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           signed_mode,
    input  logic [NUM_ADC-1:0]             ADC_DOUT,
    output logic                           ADC_CS,
    output logic                           ADC_SCLK,
    output logic [NUM_ADC*DATA_BITS-1:0]   ADC_data,
    output logic                           busy,
    output logic                           done
);

    // The half-period counter covers both the CS setup time and an SCLK half period.
    localparam int HALF_MAX = (SCLK_HALF > CS_SETUP) ? SCLK_HALF : CS_SETUP;
    localparam int HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    // The bit counter must be able to hold TOTAL_CLKS itself, so it never wraps in a frame.
    localparam int BIT_W    = $clog2(TOTAL_CLKS + 1);

    localparam logic [HALF_W-1:0] SETUP_LAST = HALF_W'(CS_SETUP - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(SCLK_HALF - 1);
    localparam logic [HALF_W-1:0] HALF_ONE   = HALF_W'(1'b1);
    localparam logic [HALF_W-1:0] HALF_ZERO  = HALF_W'(1'b0);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0]  BIT_ZERO   = BIT_W'(1'b0);
    localparam logic [BIT_W-1:0]  WIN_LO     = BIT_W'(LEAD_BITS);
    localparam logic [BIT_W-1:0]  WIN_HI     = BIT_W'(LEAD_BITS + DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_TOTAL  = BIT_W'(TOTAL_CLKS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        SHIFT_LO = 2'd2,
        SHIFT_HI = 2'd3
    } state_t;

    state_t                                 state_r;
    logic [HALF_W-1:0]                      half_cnt_r;
    logic [BIT_W-1:0]                       bit_cnt_r;
    logic                                   signed_r;
    logic                                   cs_r;
    logic                                   sclk_r;
    logic                                   busy_r;
    logic                                   done_r;
    logic [NUM_ADC-1:0][DATA_BITS-1:0]      shift_r;
    logic [NUM_ADC-1:0][DATA_BITS-1:0]      data_r;

    // Flipping the MSB maps offset binary onto two's complement.
    function automatic logic [DATA_BITS-1:0] fmt_word(
        input logic [DATA_BITS-1:0] raw,
        input logic                 sgn
    );
        fmt_word = raw ^ {sgn, {(DATA_BITS-1){1'b0}}};
    endfunction

    // Frame sequencer: drives CS, SCLK, busy and done, shifts in ADC bits and publishes results.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            half_cnt_r <= HALF_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            signed_r   <= 1'b0;
            cs_r       <= 1'b1;
            sclk_r     <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            shift_r    <= {(NUM_ADC*DATA_BITS){1'b0}};
            data_r     <= {(NUM_ADC*DATA_BITS){1'b0}};
        end else begin
            done_r <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                // Abandon the frame; the published words stay as they were.
                state_r    <= IDLE;
                half_cnt_r <= HALF_ZERO;
                bit_cnt_r  <= BIT_ZERO;
                cs_r       <= 1'b1;
                sclk_r     <= 1'b1;
                busy_r     <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        // In IDLE, abort overrides a simultaneous start.
                        if (start && !abort) begin
                            state_r    <= SETUP;
                            half_cnt_r <= HALF_ZERO;
                            bit_cnt_r  <= BIT_ZERO;
                            signed_r   <= signed_mode;
                            cs_r       <= 1'b0;
                            busy_r     <= 1'b1;
                            shift_r    <= {(NUM_ADC*DATA_BITS){1'b0}};
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    SETUP: begin
                        if (half_cnt_r == SETUP_LAST) begin
                            half_cnt_r <= HALF_ZERO;
                            state_r    <= SHIFT_LO;
                            sclk_r     <= 1'b0;
                        end else begin
                            half_cnt_r <= half_cnt_r + HALF_ONE;
                        end
                    end
                    SHIFT_LO: begin
                        if (half_cnt_r == HALF_LAST) begin
                            half_cnt_r <= HALF_ZERO;
                            state_r    <= SHIFT_HI;
                            sclk_r     <= 1'b1;
                            bit_cnt_r  <= bit_cnt_r + BIT_ONE;
                            // bit_cnt_r is the index of the rising edge being issued.
                            if ((bit_cnt_r >= WIN_LO) && (bit_cnt_r < WIN_HI)) begin
                                for (int i = 0; i < NUM_ADC; i++) begin
                                    shift_r[i] <= {shift_r[i][DATA_BITS-2:0], ADC_DOUT[i]};
                                end
                            end
                        end else begin
                            half_cnt_r <= half_cnt_r + HALF_ONE;
                        end
                    end
                    SHIFT_HI: begin
                        if (half_cnt_r == HALF_LAST) begin
                            half_cnt_r <= HALF_ZERO;
                            if (bit_cnt_r < BIT_TOTAL) begin
                                state_r <= SHIFT_LO;
                                sclk_r  <= 1'b0;
                            end else begin
                                state_r   <= IDLE;
                                bit_cnt_r <= BIT_ZERO;
                                cs_r      <= 1'b1;
                                sclk_r    <= 1'b1;
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                for (int i = 0; i < NUM_ADC; i++) begin
                                    data_r[i] <= fmt_word(shift_r[i], signed_r);
                                end
                            end
                        end else begin
                            half_cnt_r <= half_cnt_r + HALF_ONE;
                        end
                    end
                    default: begin
                        // Recover from an illegal state encoding.
                        state_r    <= IDLE;
                        half_cnt_r <= HALF_ZERO;
                        bit_cnt_r  <= BIT_ZERO;
                        cs_r       <= 1'b1;
                        sclk_r     <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ADC_CS   = cs_r;
    assign ADC_SCLK = sclk_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign ADC_data = data_r;

endmodule
